// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
//   Shared types and constants for the bit-serial adder sequencer.
//   - state_t       : sequencer FSM state (IDLE/ADD/DONE, 2-bit encoding)
//   - DEFAULT_WIDTH : default operand/result width in bits
// -----------------------------------------------------------------------------
package serial_add_pkg;

  // 2'b11 is never entered; the sequencer decodes it as IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage : serial_add_pkg

// File: rtl/serial_add_sequencer_half_adder_cell.sv
// -----------------------------------------------------------------------------
// half_adder_cell
//   Single-bit half adder, purely combinational. Two of these plus an OR gate
//   make up the full-add slice that the sequencer reuses every bit-cycle.
//
// Ports:
//   a, b : input  addend bits
//   s    : output sum bit   (a ^ b)
//   c    : output carry bit (a & b)
// -----------------------------------------------------------------------------
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule : half_adder_cell

// File: rtl/serial_add_sequencer.sv
// -----------------------------------------------------------------------------
// serial_add_sequencer
//   Bit-serial adder controller. One shared full-add slice (two half-adder
//   cells + OR) is stepped across WIDTH cycles, LSB first, to produce
//   {cout, sum} = op_a + op_b. Start/busy/done handshake; ena=0 freezes every
//   register so the whole operation simply slips by the stalled cycles.
//
// Ports:
//   clk    : input  rising-edge system clock
//   rst_n  : input  asynchronous active-low reset
//   ena    : input  design enable, low holds all state (including done)
//   start  : input  new-addition request, only honoured in IDLE with ena=1
//   op_a   : input  [WIDTH-1:0] operand A, captured on accepted start
//   op_b   : input  [WIDTH-1:0] operand B, captured on accepted start
//   busy   : output high while the FSM is in ADD
//   done   : output high for the DONE cycle (stretched while ena=0)
//   sum    : output [WIDTH-1:0] registered result, held until next completion
//   cout   : output registered carry-out, held with sum
//
// Timing (no stalls): start sampled at edge E0, busy high after E0 for WIDTH
// cycles, sum/cout/done update at E0+WIDTH, done falls at E0+WIDTH+1.
// WIDTH must be >= 2.
// -----------------------------------------------------------------------------
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_res_sh;
  logic               r_carry;
  logic [CNT_W-1:0]   r_count;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  logic               w_s1;
  logic               w_c1;
  logic               w_s;
  logic               w_c2;
  logic               w_co;
  logic [WIDTH-1:0]   w_res_next;

  // Full-add slice: HA0 adds the operand LSBs, HA1 folds in the running carry.
  half_adder_cell u_ha0 (
    .a (r_a_sh[0]),
    .b (r_b_sh[0]),
    .s (w_s1),
    .c (w_c1)
  );

  half_adder_cell u_ha1 (
    .a (w_s1),
    .b (r_carry),
    .s (w_s),
    .c (w_c2)
  );

  // The two half-adder carries can never both be 1, so OR is a full carry.
  assign w_co = w_c1 | w_c2;

  // Result bits enter at the MSB and walk down, so after WIDTH shifts the
  // first (LSB) sum bit has reached bit 0.
  assign w_res_next = {w_s, r_res_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_carry  <= 1'b0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else if (ena) begin
      case (r_state)
        ADD: begin
          r_res_sh <= w_res_next;
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_carry  <= w_co;
          r_count  <= r_count + 1'b1;
          if (r_count == LAST_BIT) begin
            // Publish the result including the bit produced this cycle.
            r_sum   <= w_res_next;
            r_cout  <= w_co;
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end

        // IDLE, and the unreachable 2'b11 which is treated exactly like IDLE.
        default: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
          if (start) begin
            r_a_sh   <= op_a;
            r_b_sh   <= op_b;
            r_carry  <= 1'b0;
            r_count  <= '0;
            r_res_sh <= '0;
            r_state  <= ADD;
            r_busy   <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule : serial_add_sequencer

// File: tb/tb_serial_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sequencer
//   Scoreboard bench. The driver issues additions (with optional enable
//   stalls, ignored start requests and done stretching), computes the expected
//   {cout,sum} with plain arithmetic plus the expected completion cycle, busy
//   length and done length, and queues them. An independent monitor on the
//   falling edge pops an entry at every rising done and compares.
// -----------------------------------------------------------------------------
module tb_serial_add_sequencer;

  localparam int W = 8;

  typedef struct {
    logic [W:0] res;
    int         due;
    int         busy_len;
    int         done_len;
  } exp_t;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena   = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] op_a  = '0;
  logic [W-1:0] op_b  = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .start (start),
    .op_a  (op_a),
    .op_b  (op_b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  logic [W:0] last_res  = '0;
  int         busy_cnt  = 0;
  int         done_cnt  = 0;
  logic       prev_done = 1'b0;
  exp_t       cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'({cout, sum}), 32'd0);
      last_res  = '0;
      busy_cnt  = 0;
      done_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      chk("busy_done_excl", 32'(busy & done), 32'd0);
      if (busy) busy_cnt++;
      if (done && !prev_done) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: done rose with empty scoreboard (cycle %0d)", cyc);
          cur.res = {cout, sum}; cur.due = cyc; cur.busy_len = busy_cnt; cur.done_len = 1;
        end else begin
          cur = sb_q.pop_front();
          chk("result", 32'({cout, sum}), 32'(cur.res));
          chk("done_cycle", 32'(cyc), 32'(cur.due));
          chk("busy_len", 32'(busy_cnt), 32'(cur.busy_len));
        end
        last_res = cur.res;
        busy_cnt = 0;
        done_cnt = 0;
      end else begin
        chk("result_hold", 32'({cout, sum}), 32'(last_res));
      end
      if (done) done_cnt++;
      if (!done && prev_done) chk("done_len", 32'(done_cnt), 32'(cur.done_len));
      prev_done = done;
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge with the DUT idle and ena=1; returns #1 after the
  // DONE->IDLE edge, so a following call is a back-to-back start.
  //   pre       : cycles of ena=0 with start=1 in IDLE before the real start
  //   gap_at    : ADD step before which ena drops for gap_len cycles
  //   spur_at   : ADD step on which a stray start with new operands is raised
  //   hold      : extra ena=0 cycles while in DONE
  //   spur_done : raise start on the DONE cycle (must be ignored)
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int pre, input int gap_at, input int gap_len,
                        input int spur_at, input int hold, input bit spur_done);
    exp_t e;
    if (pre > 0) begin
      ena = 1'b0; start = 1'b1; op_a = W'($urandom); op_b = W'($urandom);
      repeat (pre) tick();
      ena = 1'b1; start = 1'b0;
    end
    e.res      = {1'b0, a} + {1'b0, b};
    e.due      = cyc + 1 + W + gap_len;
    e.busy_len = W + gap_len;
    e.done_len = 1 + hold;
    sb_q.push_back(e);
    op_a = a; op_b = b; start = 1'b1;
    tick();
    start = 1'b0; op_a = W'($urandom); op_b = W'($urandom);
    for (int i = 0; i < W; i++) begin
      if (i == gap_at && gap_len > 0) begin
        ena = 1'b0;
        repeat (gap_len) tick();
        ena = 1'b1;
      end
      if (i == spur_at) begin
        start = 1'b1; op_a = W'($urandom); op_b = W'($urandom);
      end
      tick();
      start = 1'b0;
    end
    if (hold > 0) begin
      ena = 1'b0;
      repeat (hold) tick();
      ena = 1'b1;
    end
    start = spur_done;
    tick();
    start = 1'b0;
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with start asserted: nothing may move.
    rst_n = 1'b0; start = 1'b1; op_a = 8'hA5; op_b = 8'h5A;
    repeat (5) tick();
    rst_n = 1'b1; start = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    tick();

    run_op(8'h3C, 8'h05, 0, -1, 0, -1, 0, 1'b0);
    run_op(8'hFF, 8'h01, 0, -1, 0, -1, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 0, -1, 0, -1, 0, 1'b0);
    run_op(8'h00, 8'h00, 0, -1, 0, -1, 0, 1'b0);
    // Stray start on the 3rd ADD cycle, and on the DONE cycle.
    run_op(8'h12, 8'h34, 0, -1, 0, 2, 0, 1'b1);
    tick();

    // Abort mid-add with an asynchronous reset pulse.
    op_a = 8'h80; op_b = 8'h80; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'({cout, sum}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op(8'h80, 8'h80, 0, -1, 0, -1, 0, 1'b0);

    // Enable stall mid-add, then stretched done, then idle ena-low with start.
    run_op(8'h0F, 8'h01, 0, 3, 3, -1, 0, 1'b0);
    run_op(8'h7F, 8'h81, 0, -1, 0, -1, 2, 1'b0);
    run_op(8'h01, 8'hFE, 2, 0, 1, -1, 0, 1'b0);
    run_op(8'hAA, 8'h55, 0, W - 1, 2, W - 1, 1, 1'b1);

    for (int k = 0; k < 40; k++) begin
      run_op(W'($urandom), W'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
             int'($urandom_range(0, W - 1)),
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W - 1)) : -1,
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0,
             1'($urandom_range(0, 1)));
    end

    repeat (3) tick();
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_serial_add_sequencer
